// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: active-low hex glyphs
// (bit 7 = dp, bits 6:0 = g..a) and the all-off blank pattern.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-glyph decoder; output is the active-low g..a field
// of the shared glyph constants.
import seg_pkg::*;

module seg_hex_decode (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // NOTE: a default assignment ahead of the case keeps this purely combinational (no latch).
    always_comb begin
        seg_o = GLYPH_0[6:0];
        case (hex_i)
            4'h0: seg_o = GLYPH_0[6:0];
            4'h1: seg_o = GLYPH_1[6:0];
            4'h2: seg_o = GLYPH_2[6:0];
            4'h3: seg_o = GLYPH_3[6:0];
            4'h4: seg_o = GLYPH_4[6:0];
            4'h5: seg_o = GLYPH_5[6:0];
            4'h6: seg_o = GLYPH_6[6:0];
            4'h7: seg_o = GLYPH_7[6:0];
            4'h8: seg_o = GLYPH_8[6:0];
            4'h9: seg_o = GLYPH_9[6:0];
            4'hA: seg_o = GLYPH_A[6:0];
            4'hB: seg_o = GLYPH_B[6:0];
            4'hC: seg_o = GLYPH_C[6:0];
            4'hD: seg_o = GLYPH_D[6:0];
            4'hE: seg_o = GLYPH_E[6:0];
            default: seg_o = GLYPH_F[6:0];
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver: frame snapshot of the selected channel,
// anti-ghost guard, blinking; leading-zero blanking when SEG_LZB_EN is defined.
import seg_pkg::*;

module seg_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_CH      = 8,
    parameter int SCAN_DIV_W  = 17,
    parameter int BLINK_DIV_W = 25,
    parameter int GUARD       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(NUM_CH)-1:0]      sel,
    input  logic [NUM_CH*4*NUM_DIGITS-1:0] ch_data,
    input  logic [NUM_DIGITS-1:0]          dp_mask,
    input  logic [NUM_DIGITS-1:0]          blink_mask,
    output logic [NUM_DIGITS-1:0]          AN,
    output logic [7:0]                     SEGMENT
);

    localparam int FRAME_W = 4 * NUM_DIGITS;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // The scan prescaler is the low SCAN_DIV_W bits of the blink divider.
    logic [BLINK_DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [FRAME_W-1:0]     snap_q, snap_d;
    logic [SCAN_DIV_W-1:0]  guard_q, guard_d;
    logic                   phase_q, phase_d;
    logic                   first_q;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic [7:0]             seg_q, seg_d;

    logic       scan_tick;
    logic       blank;
    logic [3:0] nibble;
    logic [6:0] glyph;

    seg_hex_decode u_dec (
        .hex_i (nibble),
        .seg_o (glyph)
    );

`ifdef SEG_LZB_EN
    logic [NUM_DIGITS-1:0] lz;
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz       = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (snap_d[i*4 +: 4] == 4'h0);
            lz[i]    = zero_run;
        end
    end
`endif

    // Outputs are computed from next-state values so the new digit appears
    // exactly one cycle after the scan tick.
    always_comb begin
        div_d     = div_q + 1'b1;
        scan_tick = &div_q[SCAN_DIV_W-1:0];
        phase_d   = phase_q ^ (&div_q);

        idx_d = idx_q;
        if (scan_tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

        snap_d = snap_q;
        if (first_q || (scan_tick && idx_q == LAST_IDX))
            snap_d = ch_data[sel*FRAME_W +: FRAME_W];

        guard_d = guard_q;
        if (scan_tick)         guard_d = SCAN_DIV_W'(GUARD);
        else if (guard_q != 0) guard_d = guard_q - 1'b1;

        nibble = snap_d[idx_d*4 +: 4];
        blank  = phase_d & blink_mask[idx_d];
`ifdef SEG_LZB_EN
        blank  = blank | lz[idx_d];
`endif

        seg_d = blank ? SEG_BLANK : {~dp_mask[idx_d], glyph};
        an_d  = (blank || guard_d != 0) ? '1 : ~(NUM_DIGITS'(1) << idx_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            guard_q <= '0;
            phase_q <= 1'b0;
            first_q <= 1'b1;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            guard_q <= guard_d;
            phase_q <= phase_d;
            first_q <= 1'b0;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign AN      = an_q;
    assign SEGMENT = seg_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with fast dividers (scan every 8 cycles,
// blink window 64 cycles, guard 2); table vectors plus multi-cycle sequences.
module tb_seg_display_mux;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   sel = '0;
    logic [127:0] ch_data = '0;
    logic [3:0]   dp_mask = '0;
    logic [3:0]   blink_mask = '0;
    logic [3:0]   AN;
    logic [7:0]   SEGMENT;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = -1;

    always #5 clk = ~clk;

    seg_display_mux #(
        .NUM_DIGITS  (4),
        .NUM_CH      (8),
        .SCAN_DIV_W  (3),
        .BLINK_DIV_W (6),
        .GUARD       (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .ch_data    (ch_data),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .AN         (AN),
        .SEGMENT    (SEGMENT)
    );

    typedef struct {
        logic [2:0]       sel;
        logic [15:0]      data;
        logic [3:0]       dp;
        logic [3:0][7:0]  seg;
        logic [3:0]       blank;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cyc %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Sample 1 time unit after each rising edge; cyc counts edges since release.
    task automatic wait_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) wait_edge();
    endtask

    task automatic load(input logic [2:0] s, input logic [15:0] d);
        for (int k = 0; k < 8; k++) ch_data[k*16 +: 16] = 16'(16'h5555 ^ (k * 16'h1111));
        ch_data[s*16 +: 16] = d;
        sel = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_edge();
        check("reset_an", {4'h0, AN}, 8'h0F);
        check("reset_seg", SEGMENT, 8'hFF);
        wait_edge();
        rst = 1'b0;
        cyc = -1;
    endtask

    function automatic logic [3:0] an_for(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    initial begin
        vecs[0] = '{sel: 3'd2, data: 16'h1A3F, dp: 4'b0000,
                    seg: {8'hF9, 8'h88, 8'hB0, 8'h8E}, blank: 4'b0000};
`ifdef SEG_LZB_EN
        vecs[1] = '{sel: 3'd5, data: 16'h0005, dp: 4'b1000,
                    seg: {8'hFF, 8'hFF, 8'hFF, 8'h92}, blank: 4'b1110};
`else
        vecs[1] = '{sel: 3'd5, data: 16'h0005, dp: 4'b1000,
                    seg: {8'h40, 8'hC0, 8'hC0, 8'h92}, blank: 4'b0000};
`endif
        vecs[2] = '{sel: 3'd0, data: 16'h7E6B, dp: 4'b0101,
                    seg: {8'hF8, 8'h06, 8'h82, 8'h03}, blank: 4'b0000};
        vecs[3] = '{sel: 3'd7, data: 16'h9C2D, dp: 4'b0010,
                    seg: {8'h90, 8'hC6, 8'h24, 8'hA1}, blank: 4'b0000};
        vecs[4] = '{sel: 3'd3, data: 16'h8040, dp: 4'b0000,
                    seg: {8'h80, 8'hC0, 8'h99, 8'hC0}, blank: 4'b0000};

        // Table: one frame per vector, guard and steady state of every digit.
        foreach (vecs[v]) begin
            load(vecs[v].sel, vecs[v].data);
            dp_mask    = vecs[v].dp;
            blink_mask = '0;
            do_reset();
            for (int d = 0; d < 4; d++) begin
                if (d > 0) begin
                    run_to(8 * d - 1);
                    check("guard_an", {4'h0, AN}, 8'h0F);
                    check("guard_seg", SEGMENT, vecs[v].seg[d]);
                end
                run_to(8 * d + 2);
                check("digit_an", {4'h0, AN}, {4'h0, vecs[v].blank[d] ? 4'hF : an_for(d)});
                check("digit_seg", SEGMENT, vecs[v].seg[d]);
            end
        end

        // Mid-frame sel/data change must wait for the next frame.
        load(3'd2, 16'h1A3F);
        ch_data[5*16 +: 16] = 16'h5678;
        dp_mask = '0;
        do_reset();
        run_to(10);
        sel = 3'd5;
        ch_data[2*16 +: 16] = 16'h0000;
        run_to(18); check("hold_d2_an", {4'h0, AN}, 8'h0B); check("hold_d2_seg", SEGMENT, 8'h88);
        run_to(26); check("hold_d3_an", {4'h0, AN}, 8'h07); check("hold_d3_seg", SEGMENT, 8'hF9);
        run_to(34); check("new_d0_an", {4'h0, AN}, 8'h0E);  check("new_d0_seg", SEGMENT, 8'h80);
        run_to(42); check("new_d1_an", {4'h0, AN}, 8'h0D);  check("new_d1_seg", SEGMENT, 8'hF8);

        // Guard timing and one-hot AN over several frames.
        load(3'd2, 16'h1A3F);
        do_reset();
        for (int c = 1; c <= 70; c++) begin
            int lows;
            run_to(c);
            lows = 0;
            for (int b = 0; b < 4; b++) if (AN[b] == 1'b0) lows++;
            check("an_onehot", {7'h0, lows <= 1}, 8'h01);
            check("guard_window", {7'h0, AN == 4'hF}, {7'h0, (c % 8 == 7) || (c % 8 == 0)});
        end

        // Blink on digit 2: blanked only while the phase is 1 (cycles 63..126).
        load(3'd2, 16'h1A3F);
        blink_mask = 4'b0100;
        do_reset();
        run_to(18);  check("blink_d2_ph0", {4'h0, AN}, 8'h0B);
        run_to(50);  check("blink_d2_ph0b", {4'h0, AN}, 8'h0B);
        run_to(74);  check("blink_d1_ph1", {4'h0, AN}, 8'h0D);
        run_to(82);  check("blink_d2_ph1", {4'h0, AN}, 8'h0F);
        run_to(82);  check("blink_d2_seg", SEGMENT, 8'hFF);
        run_to(90);  check("blink_d3_ph1", {4'h0, AN}, 8'h07);
        run_to(114); check("blink_d2_ph1b", {4'h0, AN}, 8'h0F);
        run_to(146); check("blink_d2_ph0c", {4'h0, AN}, 8'h0B);
        blink_mask = '0;

        // Reset at idx 2 abandons the frame and restarts with a fresh snapshot.
        load(3'd2, 16'h1A3F);
        do_reset();
        run_to(18);
        check("pre_rst_an", {4'h0, AN}, 8'h0B);
        ch_data[2*16 +: 16] = 16'h2468;
        do_reset();
        run_to(2);  check("post_rst_d0_an", {4'h0, AN}, 8'h0E); check("post_rst_d0_seg", SEGMENT, 8'h80);
        run_to(10); check("post_rst_d1_an", {4'h0, AN}, 8'h0D); check("post_rst_d1_seg", SEGMENT, 8'h82);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
